fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of controller_integrated. Owns the PC, issues
//  req/ack reads to instruction memory, holds the fetched 18-bit word on inst and advances
//  only on the controller's next-PC commands (PC_inc, JAddrSelect, BrTake).
// PARAMETERS
//  AW            16      PC / imem address width
//  IW            18      instruction width
//  RESET_VECTOR  16'h0   first fetch address after reset
//  FETCH_TIMEOUT 255     cycles in REQ without imem_ack before retry (1..255)
// PORTS
//  CLK         in   1    clock, rising edge
//  CLR         in   1    asynchronous reset, active-low
//  PC_inc      in   1    advance PC by 1
//  JAddrSelect in   1    load PC from JAddr
//  JAddr       in   AW   absolute jump target
//  BrTake      in   1    PC-relative branch taken
//  BrDisp      in   8    signed branch displacement
//  imem_req    out  1    read request; held until imem_ack
//  imem_addr   out  AW   read address; equals pc while imem_req=1
//  imem_ack    in   1    read data valid this cycle
//  imem_rdata  in   IW   read data
//  inst        out  IW   instruction register
//  inst_valid  out  1    inst holds the word at pc
//  pc          out  AW   address of inst
//  pc_link     out  AW   pc+1 mod 2^AW (return address)
//  fetch_err   out  1    sticky: timeout occurred
//  cmd_err     out  1    sticky: command seen while inst_valid=0
// BEHAVIOUR
//  Reset (CLR=0, async, any state): state=RST, pc=RESET_VECTOR, inst=0, inst_valid=0,
//   imem_req=0, timeout cnt=0, fetch_err=0, cmd_err=0. In-flight fetch abandoned; an
//   imem_ack arriving in RST is ignored.
//  FSM RST -> REQ -> VALID -> REQ ...; REQ -> RETRY -> REQ on timeout.
//  RST: one cycle after CLR rises, no request; -> REQ.
//  REQ: imem_req=1, imem_addr=pc, cnt++ each cycle. imem_ack=1 (same cycle allowed):
//   inst<=imem_rdata, inst_valid<=1, cnt<=0, -> VALID. cnt reaching FETCH_TIMEOUT without
//   ack: fetch_err<=1, cnt<=0, -> RETRY.
//  RETRY: imem_req=0 for exactly one cycle; pc unchanged; -> REQ.
//  VALID: inst, pc stable. Any command: pc<=next, inst_valid<=0, -> REQ. inst keeps old
//   value until new ack.
//  next-PC priority (simultaneous assertions): JAddrSelect > BrTake > PC_inc.
//   JAddrSelect: JAddr. BrTake: pc+1+sext(BrDisp). PC_inc: pc+1. All mod 2^AW (FFFF+1=0).
//  Command in RST/REQ/RETRY: ignored, cmd_err<=1.
//  imem_ack when imem_req=0: ignored.
//  Latency: command at edge N -> imem_req=1 after N; zero-wait ack -> inst_valid=1 after
//   N+1. Steady state one instruction per 2 cycles.
//  pc_link combinational from pc; all other outputs registered.
// STRUCTURE
//  Shared package cpu_pkg: state encodings RST/REQ/RETRY/VALID, AW/IW defaults,
//   RESET_VECTOR. One sub-module, pc_next (combinational next-PC mux/adder with priority
//   and sign extension); FSM, timeout counter and IR in fetch_unit.
// TESTING
//  1 Reset, zero-wait memory returning 18'h06aff at 0 -> imem_addr=0 one cycle after CLR
//    rises; inst=18'h06aff, inst_valid=1 next cycle; pc=0, pc_link=1.
//  2 pc=16'hFFFF, PC_inc -> fetch at 16'h0000; pc_link at FFFF reads 0000.
//  3 pc=16'h0010: JAddrSelect(JAddr=16'h0200)+BrTake+PC_inc together -> fetch 16'h0200;
//    BrTake only with BrDisp=8'hFE -> 16'h000F.
//  4 Memory never acks, FETCH_TIMEOUT=4 -> fetch_err=1, one cycle imem_req=0, re-request at
//    same address; later ack completes normally.
//  5 PC_inc during REQ -> cmd_err=1, pc unchanged.
//  6 CLR low mid-REQ -> imem_req=0 at once; ack during RST ignored; fetch restarts at
//    RESET_VECTOR.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end: fetch FSM state encoding and the
// default address/instruction widths and reset vector.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_AW = 16;
  localparam int CPU_IW = 18;

  localparam logic [CPU_AW-1:0] CPU_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_REQ   = 2'd1,
    ST_RETRY = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/pc_next.sv
// ---------------------------------------------------------------------------
// pc_next
// Combinational next-PC selection for the fetch unit.
// Priority when several commands are asserted together:
//   jaddr_sel (absolute) > br_take (pc+1+sext(br_disp)) > pc_inc (pc+1).
// With no command asserted next_pc holds pc. All sums wrap modulo 2^AW.
// Ports:
//   pc        in   AW  current program counter
//   pc_inc    in   1   advance by one
//   jaddr_sel in   1   load absolute target
//   jaddr     in   AW  absolute target
//   br_take   in   1   take PC-relative branch
//   br_disp   in   8   signed branch displacement
//   next_pc   out  AW  selected next program counter
//   pc_link   out  AW  pc+1 (return address)
// ---------------------------------------------------------------------------
module pc_next
  import cpu_pkg::*;
#(
  parameter int AW = CPU_AW
) (
  input  logic [AW-1:0] pc,
  input  logic          pc_inc,
  input  logic          jaddr_sel,
  input  logic [AW-1:0] jaddr,
  input  logic          br_take,
  input  logic [7:0]    br_disp,
  output logic [AW-1:0] next_pc,
  output logic [AW-1:0] pc_link
);

  logic signed [7:0]    disp_s;
  logic signed [AW-1:0] disp_ext;
  logic        [AW-1:0] pc_plus1;
  logic        [AW-1:0] br_target;

  assign disp_s    = br_disp;
  assign disp_ext  = {{(AW-8){disp_s[7]}}, disp_s};
  assign pc_plus1  = pc + {{(AW-1){1'b0}}, 1'b1};
  assign br_target = pc_plus1 + $unsigned(disp_ext);
  assign pc_link   = pc_plus1;

  always_comb begin
    next_pc = pc;
    if (jaddr_sel) begin
      next_pc = jaddr;
    end else if (br_take) begin
      next_pc = br_target;
    end else if (pc_inc) begin
      next_pc = pc_plus1;
    end
  end

endmodule : pc_next

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the PC, reads instruction memory with a
// req/ack handshake, holds the fetched word in the instruction register and
// advances only when the downstream controller issues a next-PC command while
// the held instruction is valid. A request that sees no ack for FETCH_TIMEOUT
// cycles is dropped for one cycle and reissued at the same address.
// Ports:
//   CLK         in   1   clock, rising edge
//   CLR         in   1   asynchronous reset, active-low
//   PC_inc      in   1   advance PC by 1
//   JAddrSelect in   1   load PC from JAddr
//   JAddr       in   AW  absolute jump target
//   BrTake      in   1   PC-relative branch taken
//   BrDisp      in   8   signed branch displacement
//   imem_req    out  1   read request, held until imem_ack
//   imem_addr   out  AW  read address (equals pc)
//   imem_ack    in   1   read data valid this cycle
//   imem_rdata  in   IW  read data
//   inst        out  IW  instruction register
//   inst_valid  out  1   inst holds the word at pc
//   pc          out  AW  address of inst
//   pc_link     out  AW  pc+1 mod 2^AW
//   fetch_err   out  1   sticky: fetch timeout occurred
//   cmd_err     out  1   sticky: command seen while inst_valid=0
// ---------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int             AW            = CPU_AW,
  parameter int             IW            = CPU_IW,
  parameter logic [AW-1:0]  RESET_VECTOR  = AW'(CPU_RESET_VECTOR),
  parameter int             FETCH_TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          PC_inc,
  input  logic          JAddrSelect,
  input  logic [AW-1:0] JAddr,
  input  logic          BrTake,
  input  logic [7:0]    BrDisp,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] inst,
  output logic          inst_valid,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_link,
  output logic          fetch_err,
  output logic          cmd_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  fetch_state_t  state;
  logic [7:0]    cnt;
  logic [AW-1:0] pc_nxt;
  logic          cmd;

  assign cmd       = PC_inc | JAddrSelect | BrTake;
  // pc is a register, so the address port is still a registered output.
  assign imem_addr = pc;

  pc_next #(
    .AW (AW)
  ) u_pc_next (
    .pc        (pc),
    .pc_inc    (PC_inc),
    .jaddr_sel (JAddrSelect),
    .jaddr     (JAddr),
    .br_take   (BrTake),
    .br_disp   (BrDisp),
    .next_pc   (pc_nxt),
    .pc_link   (pc_link)
  );

  // Fetch FSM, timeout counter and instruction register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state      <= ST_RST;
      pc         <= RESET_VECTOR;
      inst       <= '0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
      cnt        <= '0;
      fetch_err  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          if (cmd) cmd_err <= 1'b1;
          imem_req <= 1'b1;
          state    <= ST_REQ;
        end
        ST_REQ: begin
          if (cmd) cmd_err <= 1'b1;
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            cnt        <= '0;
            state      <= ST_VALID;
          end else if (cnt == TIMEOUT_LAST) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            cnt       <= '0;
            state     <= ST_RETRY;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RETRY: begin
          if (cmd) cmd_err <= 1'b1;
          imem_req <= 1'b1;
          state    <= ST_REQ;
        end
        ST_VALID: begin
          // inst keeps the old word until the next ack overwrites it.
          if (cmd) begin
            pc         <= pc_nxt;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= ST_REQ;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= ST_RST;
        end
      endcase
    end
  end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int AW = 16;
  localparam int IW = 18;
  localparam int FT = 4;

  logic          CLK = 1'b0;
  logic          CLR;
  logic          PC_inc = 1'b0;
  logic          JAddrSelect = 1'b0;
  logic [AW-1:0] JAddr = '0;
  logic          BrTake = 1'b0;
  logic [7:0]    BrDisp = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] inst;
  logic          inst_valid;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_link;
  logic          fetch_err;
  logic          cmd_err;

  int checks = 0;
  int errors = 0;

  logic          ack_gate  = 1'b0;
  logic          force_ack = 1'b0;
  bit            rand_ack  = 1'b0;
  logic [AW-1:0] mpc;

  always #5 CLK = ~CLK;

  // Memory model: fixed contents derived from the address.
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 18'h06aff ^ {a, a[1:0]};
  endfunction

  // Next-PC reference computed from the command rules with integer arithmetic.
  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] p, input logic inc,
                                               input logic js, input logic [AW-1:0] ja,
                                               input logic bt, input logic [7:0] bd);
    int t;
    if (js) return ja;
    if (bt) begin
      t = int'(p) + 1 + int'($signed(bd));
      return 16'(t);
    end
    if (inc) return 16'(int'(p) + 1);
    return p;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ack   = force_ack | (ack_gate & imem_req);

  fetch_unit #(
    .AW            (AW),
    .IW            (IW),
    .RESET_VECTOR  (16'h0000),
    .FETCH_TIMEOUT (FT)
  ) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .PC_inc      (PC_inc),
    .JAddrSelect (JAddrSelect),
    .JAddr       (JAddr),
    .BrTake      (BrTake),
    .BrDisp      (BrDisp),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .pc_link     (pc_link),
    .fetch_err   (fetch_err),
    .cmd_err     (cmd_err)
  );

  // Drive a command for one clock edge, then release it.
  task automatic send_cmd(input logic inc, input logic js, input logic [AW-1:0] ja,
                          input logic bt, input logic [7:0] bd);
    PC_inc = inc; JAddrSelect = js; JAddr = ja; BrTake = bt; BrDisp = bd;
    @(posedge CLK); #1;
    PC_inc = 1'b0; JAddrSelect = 1'b0; BrTake = 1'b0;
  endtask

  // Wait (bounded) until inst_valid is observed high.
  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (inst_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      if (rand_ack) ack_gate = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    CLR = 1'b0; ack_gate = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    checks++; if (inst !== 18'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000", inst); end
    checks++; if (fetch_err !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b expected 00", fetch_err, cmd_err); end
    CLR = 1'b1;
    @(posedge CLK); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr); end
    @(posedge CLK); #1;
    checks++; if (inst_valid !== 1'b1 || inst !== 18'h06aff) begin errors++; $display("FAIL first_inst: got v=%b inst=%h expected v=1 inst=06aff", inst_valid, inst); end
    checks++; if (pc !== 16'h0000 || pc_link !== 16'h0001) begin errors++; $display("FAIL first_pc: got pc=%h link=%h expected 0000/0001", pc, pc_link); end
    mpc = 16'h0000;
  endtask

  task automatic test_pc_wrap();
    bit ok;
    send_cmd(1'b0, 1'b1, 16'hFFFF, 1'b0, 8'h00);
    wait_valid(20, ok);
    checks++; if (!ok || pc !== 16'hFFFF || pc_link !== 16'h0000) begin errors++; $display("FAIL wrap_link: got ok=%b pc=%h link=%h expected FFFF/0000", ok, pc, pc_link); end
    checks++; if (inst !== mem_word(16'hFFFF)) begin errors++; $display("FAIL wrap_inst: got %h expected %h", inst, mem_word(16'hFFFF)); end
    send_cmd(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || inst_valid !== 1'b0) begin errors++; $display("FAIL wrap_fetch: got req=%b addr=%h v=%b expected 1/0000/0", imem_req, imem_addr, inst_valid); end
    wait_valid(20, ok);
    checks++; if (!ok || pc !== 16'h0000 || inst !== mem_word(16'h0000)) begin errors++; $display("FAIL wrap_done: got ok=%b pc=%h inst=%h expected 0000/%h", ok, pc, inst, mem_word(16'h0000)); end
    mpc = 16'h0000;
  endtask

  task automatic test_priority();
    bit ok;
    send_cmd(1'b0, 1'b1, 16'h0010, 1'b0, 8'h00);
    wait_valid(20, ok);
    send_cmd(1'b1, 1'b1, 16'h0200, 1'b1, 8'($urandom));
    checks++; if (imem_addr !== 16'h0200) begin errors++; $display("FAIL prio_all: got %h expected 0200", imem_addr); end
    wait_valid(20, ok);
    checks++; if (!ok || pc !== 16'h0200 || inst !== mem_word(16'h0200)) begin errors++; $display("FAIL prio_all_done: got pc=%h inst=%h expected 0200/%h", pc, inst, mem_word(16'h0200)); end
    send_cmd(1'b0, 1'b1, 16'h0010, 1'b0, 8'h00);
    wait_valid(20, ok);
    send_cmd(1'b1, 1'b0, 16'h0000, 1'b1, 8'hFE);
    checks++; if (imem_addr !== 16'h000F) begin errors++; $display("FAIL prio_br: got %h expected 000F", imem_addr); end
    wait_valid(20, ok);
    checks++; if (!ok || pc !== 16'h000F || pc_link !== 16'h0010) begin errors++; $display("FAIL prio_br_done: got pc=%h link=%h expected 000F/0010", pc, pc_link); end
    mpc = 16'h000F;
  endtask

  task automatic test_timeout();
    bit ok;
    int hi;
    logic [AW-1:0] exp;
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_pre: got %b expected 0", fetch_err); end
    ack_gate = 1'b0;
    exp = model_next(mpc, 1'b1, 1'b0, '0, 1'b0, 8'h00);
    send_cmd(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00);
    hi = 0;
    while (imem_req === 1'b1 && hi < 20) begin
      hi++;
      @(posedge CLK); #1;
    end
    checks++; if (hi != FT) begin errors++; $display("FAIL tmo_len: got %0d cycles expected %0d", hi, FT); end
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL tmo_err: got err=%b req=%b expected 1/0", fetch_err, imem_req); end
    @(posedge CLK); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== exp) begin errors++; $display("FAIL tmo_retry: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, exp); end
    ack_gate = 1'b1;
    wait_valid(20, ok);
    checks++; if (!ok || pc !== exp || inst !== mem_word(exp) || fetch_err !== 1'b1) begin errors++; $display("FAIL tmo_done: got pc=%h inst=%h err=%b expected %h/%h/1", pc, inst, fetch_err, exp, mem_word(exp)); end
    mpc = exp;
  endtask

  task automatic test_cmd_err();
    bit ok;
    logic [AW-1:0] exp;
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL cmderr_pre: got %b expected 0", cmd_err); end
    ack_gate = 1'b0;
    exp = model_next(mpc, 1'b1, 1'b0, '0, 1'b0, 8'h00);
    send_cmd(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00);
    send_cmd(1'b1, 1'b1, 16'h1234, 1'b0, 8'h00);
    checks++; if (cmd_err !== 1'b1 || pc !== exp) begin errors++; $display("FAIL cmderr_req: got err=%b pc=%h expected 1/%h", cmd_err, pc, exp); end
    ack_gate = 1'b1;
    wait_valid(20, ok);
    checks++; if (!ok || pc !== exp || inst !== mem_word(exp)) begin errors++; $display("FAIL cmderr_done: got pc=%h inst=%h expected %h/%h", pc, inst, exp, mem_word(exp)); end
    mpc = exp;
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] r;
    logic inc, js, bt;
    logic [AW-1:0] ja, exp;
    logic [7:0] bd;
    rand_ack = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r   = $urandom;
      inc = r[0];
      js  = (r[3:1] == 3'b000);
      bt  = r[4];
      if (!inc && !js && !bt) inc = 1'b1;
      ja  = 16'($urandom);
      bd  = 8'($urandom);
      exp = model_next(mpc, inc, js, ja, bt, bd);
      send_cmd(inc, js, ja, bt, bd);
      checks++; if (inst_valid !== 1'b0 || imem_addr !== exp) begin errors++; $display("FAIL rand_issue[%0d]: got v=%b addr=%h expected 0/%h", n, inst_valid, imem_addr, exp); end
      wait_valid(60, ok);
      checks++; if (!ok || pc !== exp || inst !== mem_word(exp) || pc_link !== 16'(exp + 16'd1)) begin errors++; $display("FAIL rand_done[%0d]: got ok=%b pc=%h inst=%h link=%h expected pc=%h inst=%h", n, ok, pc, inst, pc_link, exp, mem_word(exp)); end
      mpc = exp;
    end
    rand_ack = 1'b0;
    ack_gate = 1'b1;
  endtask

  task automatic test_reset_midreq();
    ack_gate = 1'b0;
    send_cmd(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00);
    @(posedge CLK); #1;
    CLR = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL midrst_async: got req=%b v=%b pc=%h expected 0/0/0000", imem_req, inst_valid, pc); end
    force_ack = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b1;
    @(posedge CLK); #1;
    checks++; if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 16'h0000) begin errors++; $display("FAIL midrst_ignore: got req=%b v=%b addr=%h expected 1/0/0000", imem_req, inst_valid, imem_addr); end
    checks++; if (fetch_err !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL midrst_errs: got %b%b expected 00", fetch_err, cmd_err); end
    force_ack = 1'b0;
    ack_gate  = 1'b1;
    @(posedge CLK); #1;
    checks++; if (inst_valid !== 1'b1 || inst !== 18'h06aff || pc !== 16'h0000) begin errors++; $display("FAIL midrst_done: got v=%b inst=%h pc=%h expected 1/06aff/0000", inst_valid, inst, pc); end
  endtask

  initial begin
    test_reset();
    test_pc_wrap();
    test_priority();
    test_timeout();
    test_cmd_err();
    test_random();
    test_reset_midreq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_unit
